cal_trg_gen: RTL and testbench
==============================

# cal_trg_gen

Calibration trigger generator on the DMB control FPGA: the transmitting end of the calibration path into `trgcntrl`. On a start command it drives a programmable burst of calibration pulses. Each pulse is a one-cycle LCT strip pattern on `CSTRIP[5:0]`, followed after a programmable latency by a one-cycle `CGTRG`. The burst repeats for a programmed count with a programmable gap. `trgcntrl` consumes both outputs when calibration mode (`CMODE & CALTRGSEL`) and the matching `JTRGEN` bits are set.

## Interface
Parameters:
- `CNT_W`, default 8: width of the delay, gap and pulse-count fields.

Ports:
- `CLK` input, 1: system clock. One clock domain only.
- `RST` input, 1: synchronous, active-high reset.
- `START` input, 1: burst request, one-cycle pulse. Sampled only in IDLE.
- `ABORT` input, 1: terminates any burst.
- `STRIP_MASK` input, 6: strip pattern. Bit 0 is the ALCT/TMB LCT bit; bits 5:1 select CFEB 5..1.
- `LCT_L1A_DLY` input, `CNT_W`: extra cycles between the strip cycle and the trigger cycle.
- `GAP_DLY` input, `CNT_W`: idle cycles between a trigger and the next strip.
- `NPULSE` input, `CNT_W`: number of pulses in the burst.
- `CSTRIP` output, 6: calibration strip pattern. Registered.
- `CGTRG` output, 1: calibration trigger, active high. Registered.
- `BUSY` output, 1: high whenever the FSM is not in IDLE.
- `DONE` output, 1: one-cycle pulse when a burst completes normally.
- `PCNT` output, `CNT_W`: number of triggers issued in the current or last burst.

## Operation
States: IDLE, LCT, WAIT, L1A, GAP.

Transitions:
- **IDLE**
  - `START=1` and `NPULSE!=0`: latch `STRIP_MASK`, `LCT_L1A_DLY`, `GAP_DLY` and `NPULSE`; clear `PCNT`; go to LCT.
  - `START=1` and `NPULSE==0`: behaviour depends on `CAL_TRG_CONT_EN` (see Configuration).
- **LCT**
  - Drive `CSTRIP` = latched mask for exactly one cycle.
  - Go to WAIT, loading the counter with the latched delay; if the delay is 0, go straight to L1A.
- **WAIT**
  - Count down; go to L1A when the counter reaches 1.
- **L1A**
  - Drive `CGTRG=1` for one cycle; `PCNT` increments on the same edge.
  - If `PCNT+1 == NPULSE`: go to IDLE and assert `DONE` in the next cycle.
  - Otherwise: go to GAP, loading the latched gap; if the gap is 0, go straight to LCT.
- **GAP**
  - Count down, then go to LCT.

Rules and boundary cases:
- Configuration inputs are latched at start; input changes during a burst are ignored.
- `START` while `BUSY` is ignored and not queued.
- `ABORT`, in any state: go to IDLE on the next edge. `CSTRIP` and `CGTRG` are 0 from the next cycle, no `DONE` is issued, and `PCNT` holds its value.
- `ABORT` and `START` together in IDLE: `ABORT` wins and no burst starts.
- `RST`: IDLE; `CSTRIP=0`, `CGTRG=0`, `BUSY=0`, `DONE=0`, `PCNT=0`. Reset in mid-burst behaves the same, with all latched fields cleared.
- `PCNT` is `CNT_W` bits and saturates at all-ones; it never wraps.

## Timing
Let `START` be sampled high at edge t:
- `CSTRIP` is valid in cycle t+1 and `BUSY` is high from cycle t+1.
- `CGTRG` is high in cycle t+2+DLY.
- The next `CSTRIP` is in cycle t+3+DLY+GAP, so the pulse period is DLY+GAP+2 cycles.
- `DONE` is high in the cycle after the last `CGTRG`. `BUSY` is low in that same cycle.
- `CSTRIP` and `CGTRG` are never high in the same cycle.
- DLY+1 is chosen to match the `trgcntrl` cable delay plus the L1A latency setting.

## Configuration
Macro: `CAL_TRG_CONT_EN`.
- **Defined**: `NPULSE==0` selects continuous mode. Pulses repeat until `ABORT`, `DONE` is never asserted, and `PCNT` saturates.
- **Undefined**: `START` with `NPULSE==0` produces a `DONE` pulse in cycle t+1. `BUSY` stays low and no strip or trigger is issued.

## Structure
- Package `cal_trg_pkg` holds:
  - the state enumeration (`CT_IDLE`, `CT_LCT`, `CT_WAIT`, `CT_L1A`, `CT_GAP`);
  - the default `CNT_W`;
  - the strip-width constant (6).
- One sub-module, `cal_dly_cnt`: a loadable down-counter with a terminal-count flag, shared by the WAIT and GAP states.
- The FSM, the latch registers and the output registers stay in the top module.

## Test plan
1. **Normal burst**: mask=6'b000110, DLY=3, GAP=2, NPULSE=2, `START` at edge 0 → `CSTRIP`=000110 in cycles 1 and 8; `CGTRG` in cycles 5 and 12; `DONE` in cycle 13; `PCNT`=2.
2. **Zero delays**: DLY=0, GAP=0, NPULSE=3 → `CSTRIP` in cycles 1, 3, 5; `CGTRG` in cycles 2, 4, 6; `DONE` in cycle 7.
3. **Abort mid-burst**: `ABORT` asserted during WAIT of pulse 2 → outputs 0 from the next cycle, no `DONE`, `PCNT`=1, `BUSY` low.
4. **Busy and priority**: `START` re-issued while `BUSY` → no effect on timing. `START`+`ABORT` together in IDLE → `BUSY` stays 0.
5. **NPULSE=0**:
   - With `CAL_TRG_CONT_EN`: period-7 pulses continue past 300 triggers, `PCNT` holds at 255, and `ABORT` stops the burst.
   - Without it: `DONE` in cycle 1 and no outputs.
6. **Reset mid-burst**: `RST` during GAP → all outputs 0 on the next cycle; a subsequent `START` gives the test 1 timing again.

Source files
------------

// File: rtl/cal_trg_pkg.sv
// Shared types and constants for the calibration trigger generator.
package cal_trg_pkg;

  localparam int unsigned CT_DEF_CNT_W = 8;
  localparam int unsigned CT_STRIP_W   = 6;

  typedef enum logic [2:0] {
    CT_IDLE,
    CT_LCT,
    CT_WAIT,
    CT_L1A,
    CT_GAP
  } ct_state_t;

endpackage

// File: rtl/cal_dly_cnt.sv
// Loadable down-counter with terminal-count flag, shared by the WAIT and GAP
// phases of the calibration trigger generator. o_tc is high while the count is 1,
// so a load of N yields exactly N cycles before the terminal transition.
module cal_dly_cnt
  import cal_trg_pkg::*;
#(
  parameter int unsigned CNT_W = CT_DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/cal_trg_gen.sv
// Calibration trigger generator: emits bursts of one-cycle CSTRIP patterns,
// each followed by a delayed one-cycle CGTRG, with a programmable gap.
// Optional feature macro: CAL_TRG_CONT_EN (NPULSE==0 selects continuous mode).
module cal_trg_gen
  import cal_trg_pkg::*;
#(
  parameter int unsigned CNT_W = CT_DEF_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [CT_STRIP_W-1:0] STRIP_MASK,
  input  logic [CNT_W-1:0]      LCT_L1A_DLY,
  input  logic [CNT_W-1:0]      GAP_DLY,
  input  logic [CNT_W-1:0]      NPULSE,
  output logic [CT_STRIP_W-1:0] CSTRIP,
  output logic                  CGTRG,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [CNT_W-1:0]      PCNT
);

  ct_state_t             r_state;
  ct_state_t             w_state_nxt;

  logic [CT_STRIP_W-1:0] r_mask;
  logic [CNT_W-1:0]      r_dly;
  logic [CNT_W-1:0]      r_gap;
  logic [CNT_W-1:0]      r_npulse;
  logic [CNT_W-1:0]      r_pcnt;
  logic [CT_STRIP_W-1:0] r_cstrip;
  logic                  r_cgtrg;
  logic                  r_done;

  logic                  w_cnt_load;
  logic [CNT_W-1:0]      w_cnt_val;
  logic                  w_cnt_tc;
  logic                  w_latch;
  logic                  w_pcnt_inc;
  logic                  w_done_set;
  logic                  w_last;
  logic                  w_start_ok;
  logic [CT_STRIP_W-1:0] w_mask_sel;

  // Widened compare so a saturated PCNT cannot wrap into a match with NPULSE==0.
  assign w_last = (({1'b0, r_pcnt} + (CNT_W+1)'(1)) == {1'b0, r_npulse});

`ifdef CAL_TRG_CONT_EN
  assign w_start_ok = 1'b1;
`else
  assign w_start_ok = (NPULSE != '0);
`endif

  // Outputs are registered from the next state, so the strip pattern must come
  // from the live inputs on the start edge and from the latch afterwards.
  assign w_mask_sel = (r_state == CT_IDLE) ? STRIP_MASK : r_mask;

  cal_dly_cnt #(
    .CNT_W(CNT_W)
  ) u_dly_cnt (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_tc       (w_cnt_tc)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= CT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; ABORT overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CT_IDLE: if (START && w_start_ok) w_state_nxt = CT_LCT;
      CT_LCT:  w_state_nxt = (r_dly == '0) ? CT_L1A : CT_WAIT;
      CT_WAIT: if (w_cnt_tc) w_state_nxt = CT_L1A;
      CT_L1A: begin
        if (w_last)              w_state_nxt = CT_IDLE;
        else if (r_gap == '0)    w_state_nxt = CT_LCT;
        else                     w_state_nxt = CT_GAP;
      end
      CT_GAP:  if (w_cnt_tc) w_state_nxt = CT_LCT;
      default: w_state_nxt = CT_IDLE;
    endcase
    if (ABORT) w_state_nxt = CT_IDLE;
  end

  // Per-state control strobes for the counter, latches, PCNT and DONE.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_latch    = 1'b0;
    w_pcnt_inc = 1'b0;
    w_done_set = 1'b0;
    if (!ABORT) begin
      case (r_state)
        CT_IDLE: begin
          w_latch = START && w_start_ok;
`ifndef CAL_TRG_CONT_EN
          w_done_set = START && (NPULSE == '0);
`endif
        end
        CT_LCT: begin
          w_cnt_load = 1'b1;
          w_cnt_val  = r_dly;
        end
        CT_L1A: begin
          w_pcnt_inc = 1'b1;
          w_done_set = w_last;
          w_cnt_load = 1'b1;
          w_cnt_val  = r_gap;
        end
        default: ;
      endcase
    end
  end

  // Burst configuration captured at start; ignored for the rest of the burst.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mask   <= '0;
      r_dly    <= '0;
      r_gap    <= '0;
      r_npulse <= '0;
    end else if (w_latch) begin
      r_mask   <= STRIP_MASK;
      r_dly    <= LCT_L1A_DLY;
      r_gap    <= GAP_DLY;
      r_npulse <= NPULSE;
    end
  end

  // Saturating trigger counter, cleared at burst start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pcnt <= '0;
    end else if (w_latch) begin
      r_pcnt <= '0;
    end else if (w_pcnt_inc && (r_pcnt != '1)) begin
      r_pcnt <= r_pcnt + CNT_W'(1);
    end
  end

  // Registered outputs driven from the upcoming state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cstrip <= '0;
      r_cgtrg  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_cstrip <= (w_state_nxt == CT_LCT) ? w_mask_sel : '0;
      r_cgtrg  <= (w_state_nxt == CT_L1A);
      r_done   <= w_done_set;
    end
  end

  assign CSTRIP = r_cstrip;
  assign CGTRG  = r_cgtrg;
  assign DONE   = r_done;
  assign PCNT   = r_pcnt;
  assign BUSY   = (r_state != CT_IDLE);

endmodule

// File: tb/tb_cal_trg_gen.sv
// Directed, table-driven bench for cal_trg_gen. Cycle c means the cycle
// after the c-th rising edge, counting the START-sampling edge as edge 0.
module tb_cal_trg_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [5:0] STRIP_MASK = '0;
  logic [7:0] LCT_L1A_DLY = '0;
  logic [7:0] GAP_DLY = '0;
  logic [7:0] NPULSE = '0;
  logic [5:0] CSTRIP;
  logic       CGTRG;
  logic       BUSY;
  logic       DONE;
  logic [7:0] PCNT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  cal_trg_gen #(.CNT_W(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .ABORT       (ABORT),
    .STRIP_MASK  (STRIP_MASK),
    .LCT_L1A_DLY (LCT_L1A_DLY),
    .GAP_DLY     (GAP_DLY),
    .NPULSE      (NPULSE),
    .CSTRIP      (CSTRIP),
    .CGTRG       (CGTRG),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .PCNT        (PCNT)
  );

  typedef struct {
    logic [5:0] mask;
    logic [7:0] dly;
    logic [7:0] gap;
    logic [7:0] np;
    int         done_cyc;
    logic [7:0] pcnt;
    int         restart_cyc;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cstrip"}, 32'(CSTRIP), 0);
    check({tag, " cgtrg"},  32'(CGTRG),  0);
    check({tag, " busy"},   32'(BUSY),   0);
    check({tag, " done"},   32'(DONE),   0);
  endtask

  // Drive one burst and compare every cycle against the hand-tabulated timing.
  task automatic run_burst(input vec_t v);
    int         p;
    logic [5:0] e_strip;
    logic       e_trg;
    p = int'(v.dly) + int'(v.gap) + 2;
    @(negedge CLK);
    STRIP_MASK  = v.mask;
    LCT_L1A_DLY = v.dly;
    GAP_DLY     = v.gap;
    NPULSE      = v.np;
    START       = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= v.done_cyc + 2; c++) begin
      @(negedge CLK);
      e_strip = '0;
      e_trg   = 1'b0;
      for (int k = 0; k < int'(v.np); k++) begin
        if (c == 1 + k * p) e_strip = v.mask;
        if (c == 2 + int'(v.dly) + k * p) e_trg = 1'b1;
      end
      check($sformatf("cstrip@c%0d", c), 32'(CSTRIP), 32'(e_strip));
      check($sformatf("cgtrg@c%0d", c),  32'(CGTRG),  32'(e_trg));
      check($sformatf("done@c%0d", c),   32'(DONE),   32'(c == v.done_cyc));
      check($sformatf("busy@c%0d", c),   32'(BUSY),   32'(c < v.done_cyc));
      if (c == 1) begin
        // Scramble the configuration to show it was latched at start.
        STRIP_MASK  = ~v.mask;
        LCT_L1A_DLY = v.dly + 8'd4;
        GAP_DLY     = v.gap + 8'd1;
        NPULSE      = v.np + 8'd3;
      end
      START = (c == v.restart_cyc);
    end
    START = 1'b0;
    check("pcnt_end", 32'(PCNT), 32'(v.pcnt));
  endtask

  initial begin
    vecs[0] = '{mask: 6'b000110, dly: 8'd3, gap: 8'd2, np: 8'd2, done_cyc: 13, pcnt: 8'd2, restart_cyc: 3};
    vecs[1] = '{mask: 6'b101010, dly: 8'd0, gap: 8'd0, np: 8'd3, done_cyc: 7,  pcnt: 8'd3, restart_cyc: 0};
    vecs[2] = '{mask: 6'b000001, dly: 8'd1, gap: 8'd5, np: 8'd1, done_cyc: 4,  pcnt: 8'd1, restart_cyc: 0};
    vecs[3] = '{mask: 6'b111111, dly: 8'd0, gap: 8'd3, np: 8'd2, done_cyc: 8,  pcnt: 8'd2, restart_cyc: 4};

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    check("reset pcnt", 32'(PCNT), 0);
    RST = 1'b0;

    // Normal bursts, including START re-issued while busy
    foreach (vecs[i]) run_burst(vecs[i]);

    // Abort during WAIT of pulse 2 (WAIT spans cycles 9..11)
    @(negedge CLK);
    STRIP_MASK = 6'b000110; LCT_L1A_DLY = 8'd3; GAP_DLY = 8'd2; NPULSE = 8'd2;
    START = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      START = 1'b0;
      if (c == 9) check("abort pre busy", 32'(BUSY), 1);
    end
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    check_all_zero("abort");
    check("abort pcnt", 32'(PCNT), 1);
    for (int c = 11; c <= 15; c++) begin
      @(negedge CLK);
      check($sformatf("abort done@c%0d", c), 32'(DONE), 0);
      check($sformatf("abort cgtrg@c%0d", c), 32'(CGTRG), 0);
    end

    // START and ABORT together in IDLE
    @(negedge CLK);
    START = 1'b1; ABORT = 1'b1; NPULSE = 8'd2;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    check_all_zero("start+abort c1");
    @(negedge CLK);
    check_all_zero("start+abort c2");

    // NPULSE == 0
    @(negedge CLK);
    STRIP_MASK = 6'b010101; LCT_L1A_DLY = 8'd3; GAP_DLY = 8'd2; NPULSE = 8'd0;
    START = 1'b1;
    @(posedge CLK);
`ifdef CAL_TRG_CONT_EN
    begin
      int ntrg;
      ntrg = 0;
      for (int c = 1; c <= 2120; c++) begin
        @(negedge CLK);
        START = 1'b0;
        if (CGTRG) ntrg++;
        check($sformatf("cont cgtrg@c%0d", c), 32'(CGTRG), 32'((c >= 5) && ((c - 5) % 7 == 0)));
        if (DONE) check($sformatf("cont done@c%0d", c), 32'(DONE), 0);
      end
      check("cont >300 triggers", 32'(ntrg > 300), 1);
      check("cont pcnt sat", 32'(PCNT), 255);
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      check_all_zero("cont abort");
      check("cont abort pcnt", 32'(PCNT), 255);
    end
`else
    @(negedge CLK);
    START = 1'b0;
    check("np0 done", 32'(DONE), 1);
    check("np0 busy", 32'(BUSY), 0);
    check("np0 cstrip", 32'(CSTRIP), 0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge CLK);
      check_all_zero($sformatf("np0 c%0d", c));
    end
`endif

    // Reset during GAP of pulse 1 (GAP spans cycles 6..7)
    @(negedge CLK);
    STRIP_MASK = 6'b000110; LCT_L1A_DLY = 8'd3; GAP_DLY = 8'd2; NPULSE = 8'd2;
    START = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      START = 1'b0;
      if (c == 6) check("rst pre pcnt", 32'(PCNT), 1);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_all_zero("mid rst");
    check("mid rst pcnt", 32'(PCNT), 0);
    run_burst(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
